sha2_compress: RTL
==================

SHA2_COMPRESS -- requirements
Module: sha2_compress

Interface
REQ-001 Parameter WORD_W, 32, word width: 32 selects SHA-256 (64 rounds), 64 selects SHA-512 (80 rounds); any other value SHALL fail elaboration.
REQ-002 Parameter UNROLL, 1, rounds per clock: legal 1, 2, 4; any other value SHALL fail elaboration.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  request carries a block and chaining state.
REQ-006 in_ready  output  1  block accepts a request.
REQ-007 in_block  input  16*WORD_W  message block, word 0 in MSBs.
REQ-008 in_state  input  8*WORD_W  chaining value H0..H7, H0 in MSBs.
REQ-009 out_valid  output  1  digest available.
REQ-010 out_ready  input  1  consumer takes digest.
REQ-011 out_digest  output  8*WORD_W  updated chaining value, H0 in MSBs.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL be an FSM with states IDLE, RUN, DONE.
REQ-014 IDLE: in_ready=1. On the handshake edge (in_valid&in_ready), a..h and a saved H copy SHALL load from in_state, the 16-word schedule window SHALL load from in_block, round counter=0, state->RUN.
REQ-015 RUN: in_ready=0. Each edge applies UNROLL rounds: t = counter..counter+UNROLL-1, standard SHA-2 round (T1=h+S1(e)+Ch+K[t]+W[t], T2=S0(a)+Maj), all sums modulo 2^WORD_W. Counter advances by UNROLL.
REQ-016 Sigma/sigma rotation amounts SHALL follow FIPS 180-4 for the selected WORD_W.
REQ-017 Schedule: W[t] for t<16 from the window; for t>=16, W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16]. The window SHALL slide by UNROLL words per edge; no 64/80-entry W storage.
REQ-018 RUN SHALL last exactly N=ROUNDS/UNROLL edges. On the Nth edge out_digest SHALL be written as saved H[i]+working var i (mod 2^WORD_W), out_valid->1, state->DONE.
REQ-019 Latency: out_valid SHALL be observed high N cycles after the accepting edge (SHA-256: 64/32/16; SHA-512: 80/40/20 for UNROLL 1/2/4).
REQ-020 DONE: out_valid=1, out_digest stable until out_ready=1; on that edge out_valid->0, state->IDLE. in_ready SHALL stay 0 in DONE (no overlap).
REQ-021 in_valid in RUN/DONE SHALL be ignored, with no side effect.
REQ-022 out_ready while out_valid=0 SHALL have no effect.
REQ-023 out_digest SHALL hold its last value in IDLE and RUN until overwritten by REQ-018.

Reset
REQ-024 rst_n low SHALL asynchronously force: state=IDLE, counter=0, out_valid=0, out_digest=0, working vars, saved H, and window=0; in_ready=1, busy=0 once state=IDLE.
REQ-025 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; the first handshake after release SHALL compute correctly.

Structure
REQ-026 Package sha2_pkg SHALL hold: K256[0:63], K512[0:79], SHA-256/SHA-512 IVs, rotr function, round-count function of WORD_W, FSM state enum.
REQ-027 Sub-module sha2_round (parametrised WORD_W, purely combinational single round) SHALL be instantiated UNROLL times in a chain; a schedule-expansion function in sha2_pkg SHALL supply W.
REQ-028 No multicycle or false-path constraints; critical path = UNROLL chained rounds.

Verification
REQ-029 WORD_W=32, UNROLL=1: IV256 + padded "abc" -> out_digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid at cycle 64.
REQ-030 WORD_W=32, UNROLL=4: two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnolmnopnopq", chained through in_state -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1, 16 cycles per block.
REQ-031 WORD_W=64, UNROLL=2: IV512 + padded "abc" -> H0=ddaf35a193617aba, H7=a54ca49f (low word), out_valid at cycle 40.
REQ-032 Backpressure: out_ready=0 for 10 cycles after out_valid -> digest stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-033 rst_n pulsed low at RUN round 30 -> out_valid=0, out_digest=0 immediately, no digest emitted; next "abc" request yields the REQ-029 value.

Source files
------------

// File: rtl/sha2_pkg.sv
// rtl/sha2_pkg.sv - SHA-2 constants, IVs, sigma helpers, schedule expansion and FSM state type
package sha2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sha2_state_t;

   localparam logic [255:0] IV256 =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [511:0] IV512 = {
      64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
      64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

   localparam logic [31:0] K256 [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [63:0] K512 [0:79] = '{
      64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
      64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
      64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
      64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
      64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
      64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
      64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
      64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
      64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
      64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
      64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
      64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
      64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
      64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
      64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
      64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
      64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
      64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
      64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
      64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

   function automatic int rounds(input int w);
      return (w == 64) ? 80 : 64;
   endfunction

   // Helpers carry words zero-extended to 64 bits; w selects 32- or 64-bit semantics.
   function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
      logic [63:0] r;
      if (w == 32) r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
      else         r = (x >> n) | (x << (64 - n));
      return r;
   endfunction

   function automatic logic [63:0] big_sigma0(input logic [63:0] x, input int w);
      if (w == 32) return rotr(x, 2, w) ^ rotr(x, 13, w) ^ rotr(x, 22, w);
      else         return rotr(x, 28, w) ^ rotr(x, 34, w) ^ rotr(x, 39, w);
   endfunction

   function automatic logic [63:0] big_sigma1(input logic [63:0] x, input int w);
      if (w == 32) return rotr(x, 6, w) ^ rotr(x, 11, w) ^ rotr(x, 25, w);
      else         return rotr(x, 14, w) ^ rotr(x, 18, w) ^ rotr(x, 41, w);
   endfunction

   function automatic logic [63:0] small_sigma0(input logic [63:0] x, input int w);
      if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
      else         return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
   endfunction

   function automatic logic [63:0] small_sigma1(input logic [63:0] x, input int w);
      if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
      else         return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
   endfunction

   function automatic logic [63:0] sched_word(input logic [63:0] w2, input logic [63:0] w7,
                                              input logic [63:0] w15, input logic [63:0] w16,
                                              input int w);
      logic [63:0] s;
      s = small_sigma1(w2, w) + w7 + small_sigma0(w15, w) + w16;
      if (w == 32) s = {32'h0, s[31:0]};
      return s;
   endfunction

   function automatic logic [63:0] k_const(input logic [6:0] t, input int w);
      if (w == 32) return {32'h0, K256[t[5:0]]};
      else         return K512[t];
   endfunction

endpackage

// File: rtl/sha2_round.sv
// rtl/sha2_round.sv - one combinational SHA-2 round over the packed {a..h} working state
module sha2_round
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic [8*WORD_W-1:0] st_in,
   input  logic [WORD_W-1:0]   k,
   input  logic [WORD_W-1:0]   w,
   output logic [8*WORD_W-1:0] st_out
);

   logic [WORD_W-1:0] a, b, c, d, e, f, g, h;
   logic [WORD_W-1:0] ch, maj, t1, t2;

   assign {a, b, c, d, e, f, g, h} = st_in;
   assign ch  = (e & f) ^ (~e & g);
   assign maj = (a & b) ^ (a & c) ^ (b & c);
   assign t1  = h + WORD_W'(big_sigma1(64'(e), WORD_W)) + ch + k + w;
   assign t2  = WORD_W'(big_sigma0(64'(a), WORD_W)) + maj;
   assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha2_compress.sv
// rtl/sha2_compress.sv - SHA-256/SHA-512 block compression, UNROLL rounds per clock
module sha2_compress
   import sha2_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int UNROLL = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [16*WORD_W-1:0] in_block,
   input  logic [8*WORD_W-1:0]  in_state,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [8*WORD_W-1:0]  out_digest,
   output logic                 busy
);

   localparam int CW = 7;
   localparam int ROUNDS = rounds(WORD_W);
   localparam logic [CW-1:0] LAST = CW'(ROUNDS - UNROLL);

   if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha2_compress: WORD_W must be 32 or 64");
   end
   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
      $error("sha2_compress: UNROLL must be 1, 2 or 4");
   end

   sha2_state_t state, state_nxt;
   logic [CW-1:0] cnt;
   logic [8*WORD_W-1:0] work, hsave, round_out, digest_nxt;
   logic [WORD_W-1:0] win [0:15];
   logic [WORD_W-1:0] win_nxt [0:15];
   logic [WORD_W-1:0] ext [0:19];
   logic load, step, finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = 1'b1;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (cnt == LAST) begin
               finish    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign out_valid = (state == ST_DONE);

   // Rounds of this edge consume window words 0..UNROLL-1; new words are appended at the tail.
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = win[i];
      for (int i = 16; i < 20; i++) ext[i] = '0;
      for (int j = 0; j < UNROLL; j++)
         ext[16+j] = WORD_W'(sched_word(64'(ext[14+j]), 64'(ext[9+j]),
                                        64'(ext[1+j]), 64'(ext[j]), WORD_W));
      for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+UNROLL];
   end

   for (genvar u = 0; u < UNROLL; u++) begin : g_rnd
      logic [8*WORD_W-1:0] st_i, st_o;
      logic [WORD_W-1:0]   kt;
      if (u == 0) begin : g_first
         assign st_i = work;
      end else begin : g_next
         assign st_i = g_rnd[u-1].st_o;
      end
      assign kt = WORD_W'(k_const(cnt + CW'(u), WORD_W));
      sha2_round #(.WORD_W(WORD_W)) u_round (
         .st_in  (st_i),
         .k      (kt),
         .w      (win[u]),
         .st_out (st_o)
      );
   end

   assign round_out = g_rnd[UNROLL-1].st_o;

   always_comb begin
      digest_nxt = '0;
      for (int i = 0; i < 8; i++)
         digest_nxt[i*WORD_W +: WORD_W] = hsave[i*WORD_W +: WORD_W] + round_out[i*WORD_W +: WORD_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         work       <= '0;
         hsave      <= '0;
         out_digest <= '0;
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else if (load) begin
         cnt   <= '0;
         work  <= in_state;
         hsave <= in_state;
         for (int i = 0; i < 16; i++) win[i] <= in_block[(15-i)*WORD_W +: WORD_W];
      end else if (step) begin
         cnt  <= cnt + CW'(UNROLL);
         work <= round_out;
         for (int i = 0; i < 16; i++) win[i] <= win_nxt[i];
         if (finish) out_digest <= digest_nxt;
      end
   end

endmodule
